// File: rtl/next_state_selector_pkg.sv
// next_state_selector_pkg
//   Shared control-unit definitions used by the microsequencer:
//   microstate address type, next-state select and condition select
//   encodings, and the default fault microstate.
package next_state_selector_pkg;

    typedef logic [9:0] state_addr_t;

    localparam state_addr_t FAULT_STATE_DEFAULT = 10'd127;

    // Next-state select field (N2..N0) of the control word.
    typedef enum logic [2:0] {
        NS_ENC   = 3'd0,
        NS_FETCH = 3'd1,
        NS_CR    = 3'd2,
        NS_COND  = 3'd3,
        NS_INC   = 3'd4,
        NS_CALL  = 3'd5,
        NS_RET   = 3'd6,
        NS_HOLD  = 3'd7
    } ns_sel_e;

    // Condition source select.
    typedef enum logic [1:0] {
        COND_MOC  = 2'd0,
        COND_TRUE = 2'd1,
        COND_IR_L = 2'd2,
        COND_ONE  = 2'd3
    } cond_sel_e;

endpackage

// File: rtl/micro_return_stack.sv
// micro_return_stack
//   LIFO of micro-subroutine return addresses.
//   Ports:
//     clk, reset       rising-edge clock, synchronous active-high reset
//     push, push_data  store push_data on top (ignored when full)
//     pop              discard top entry (ignored when empty)
//     pop_data         current top entry (undefined when empty)
//     full, empty      occupancy flags
//   Reset empties the stack; stored entries are not cleared and are
//   unreachable until overwritten by later pushes.
module micro_return_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] sp;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    assign full    = (sp == PTR_W'(DEPTH));
    assign empty   = (sp == '0);
    assign wr_idx  = IDX_W'(sp);
    assign top_idx = IDX_W'(sp - PTR_W'(1));
    assign pop_data = mem[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + PTR_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/next_state_selector.sv
// next_state_selector
//   Clocked microsequencer: selects and registers the next microstore
//   address each cycle, with a memory-wait watchdog and an optional
//   micro-subroutine return stack (build macro MICRO_CALL_EN).
//   Ports:
//     clk, reset     rising-edge clock, synchronous active-high reset
//     current_state  state presented by the microstore
//     ns_sel         next-state select field of the control word
//     inv, cond_sel  condition inversion and condition source
//     cr_addr        control-word target address
//     enc_state      instruction encoder dispatch address
//     moc, cond_true, ir_l  condition inputs
//     next_state     registered next microstate (microstore address)
//     mem_timeout    sticky watchdog-expiry flag
//     stack_err      sticky stack overflow/underflow flag (0 without
//                    MICRO_CALL_EN)
module next_state_selector
    import next_state_selector_pkg::*;
#(
    parameter state_addr_t FAULT_STATE = FAULT_STATE_DEFAULT,
    parameter int unsigned MOC_TIMEOUT = 16,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] current_state,
    input  logic [2:0] ns_sel,
    input  logic       inv,
    input  logic [1:0] cond_sel,
    input  logic [9:0] cr_addr,
    input  logic [9:0] enc_state,
    input  logic       moc,
    input  logic       cond_true,
    input  logic       ir_l,
    output logic [9:0] next_state,
    output logic       mem_timeout,
    output logic       stack_err
);

    state_addr_t inc;
    state_addr_t ns_d;
    logic        cond_raw;
    logic        cond;
    logic        wd_wait;
    logic        wd_expire;
    logic [4:0]  wd_cnt;
    logic        stk_push;
    logic        stk_pop;
    logic        stk_err_set;

    assign inc  = current_state + 10'd1;
    assign cond = cond_raw ^ inv;

    always_comb begin
        cond_raw = 1'b1;
        case (cond_sel_e'(cond_sel))
            COND_MOC:  cond_raw = moc;
            COND_TRUE: cond_raw = cond_true;
            COND_IR_L: cond_raw = ir_l;
            COND_ONE:  cond_raw = 1'b1;
        endcase
    end

    // A memory wait is a conditional self-loop on moc; count cycles spent
    // taking that loop and escape to FAULT_STATE on the MOC_TIMEOUT-th.
    assign wd_wait   = (ns_sel == NS_COND) && (cond_sel == COND_MOC) &&
                       cond && (cr_addr == current_state);
    assign wd_expire = wd_wait && (wd_cnt == 5'(MOC_TIMEOUT - 1));

`ifdef MICRO_CALL_EN
    state_addr_t stk_top;
    logic        stk_full;
    logic        stk_empty;
    logic        stack_err_q;

    micro_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (10)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (inc),
        .pop_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stack_err_q <= 1'b0;
        end else if (stk_err_set) begin
            stack_err_q <= 1'b1;
        end
    end

    assign stack_err = stack_err_q;
`else
    assign stack_err = 1'b0;
`endif

    always_comb begin
        ns_d        = inc;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_err_set = 1'b0;
        case (ns_sel_e'(ns_sel))
            NS_ENC:   ns_d = enc_state;
            NS_FETCH: ns_d = '0;
            NS_CR:    ns_d = cr_addr;
            NS_COND:  ns_d = cond ? cr_addr : inc;
            NS_INC:   ns_d = inc;
`ifdef MICRO_CALL_EN
            NS_CALL: begin
                ns_d = cr_addr;
                if (stk_full) begin
                    stk_err_set = 1'b1;
                end else begin
                    stk_push = 1'b1;
                end
            end
            NS_RET: begin
                if (stk_empty) begin
                    ns_d        = '0;
                    stk_err_set = 1'b1;
                end else begin
                    ns_d    = stk_top;
                    stk_pop = 1'b1;
                end
            end
`else
            NS_CALL,
            NS_RET:   ns_d = inc;
`endif
            NS_HOLD:  ns_d = current_state;
        endcase
        // Expiry needs ns_sel=NS_COND, so it never collides with a stack op.
        if (wd_expire) begin
            ns_d = FAULT_STATE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            next_state  <= '0;
            mem_timeout <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            next_state <= ns_d;
            if (wd_expire) begin
                mem_timeout <= 1'b1;
            end
            wd_cnt <= (wd_wait && !wd_expire) ? wd_cnt + 5'd1 : '0;
        end
    end

endmodule

// File: tb/tb_next_state_selector.sv
// tb_next_state_selector
//   Directed, table-driven bench for next_state_selector, plus short
//   hand-written sequences for the memory-wait watchdog and (when
//   MICRO_CALL_EN is defined) the return stack.
module tb_next_state_selector;

    typedef struct {
        logic       rst;
        logic [9:0] cs;
        logic [2:0] ns;
        logic       inv;
        logic [1:0] csel;
        logic [9:0] cr;
        logic [9:0] enc;
        logic       moc;
        logic       ct;
        logic       irl;
        logic [9:0] e_ns;
        logic       e_to;
        logic       e_se;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [9:0] current_state;
    logic [2:0] ns_sel;
    logic       inv;
    logic [1:0] cond_sel;
    logic [9:0] cr_addr;
    logic [9:0] enc_state;
    logic       moc;
    logic       cond_true;
    logic       ir_l;
    logic [9:0] next_state;
    logic       mem_timeout;
    logic       stack_err;

    int checks   = 0;
    int failures = 0;

    next_state_selector #(
        .FAULT_STATE (10'd127),
        .MOC_TIMEOUT (16),
        .STACK_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .current_state (current_state),
        .ns_sel        (ns_sel),
        .inv           (inv),
        .cond_sel      (cond_sel),
        .cr_addr       (cr_addr),
        .enc_state     (enc_state),
        .moc           (moc),
        .cond_true     (cond_true),
        .ir_l          (ir_l),
        .next_state    (next_state),
        .mem_timeout   (mem_timeout),
        .stack_err     (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_time_limit actual=not_finished required=finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        reset         = v.rst;
        current_state = v.cs;
        ns_sel        = v.ns;
        inv           = v.inv;
        cond_sel      = v.csel;
        cr_addr       = v.cr;
        enc_state     = v.enc;
        moc           = v.moc;
        cond_true     = v.ct;
        ir_l          = v.irl;
        @(posedge clk);
        #1;
        check({name, ".next_state"}, 32'(next_state), 32'(v.e_ns));
        check({name, ".mem_timeout"}, 32'(mem_timeout), 32'(v.e_to));
        check({name, ".stack_err"}, 32'(stack_err), 32'(v.e_se));
    endtask

    // Plain control word at state cs; expected flags clear.
    function automatic vec_t op(input logic [2:0] ns, input logic [9:0] cs,
                                input logic [9:0] cr, input logic [9:0] e_ns);
        vec_t v;
        v = '{rst: 1'b0, cs: cs, ns: ns, inv: 1'b0, csel: 2'd1, cr: cr,
              enc: 10'd0, moc: 1'b0, ct: 1'b0, irl: 1'b0,
              e_ns: e_ns, e_to: 1'b0, e_se: 1'b0};
        return v;
    endfunction

    // Memory-wait microinstruction looping at state 65.
    function automatic vec_t wait65(input logic m, input logic [9:0] e_ns, input logic e_to);
        vec_t v;
        v = '{rst: 1'b0, cs: 10'd65, ns: 3'd3, inv: 1'b1, csel: 2'd0, cr: 10'd65,
              enc: 10'd0, moc: m, ct: 1'b0, irl: 1'b0,
              e_ns: e_ns, e_to: e_to, e_se: 1'b0};
        return v;
    endfunction

    vec_t tbl [12];
    vec_t v;

    initial begin
        // rst cs ns inv csel cr enc moc ct irl | e_ns e_to e_se
        tbl[0]  = '{1'b1, 10'd900, 3'd0, 1'b1, 2'd2, 10'd33,  10'd55, 1'b1, 1'b1, 1'b1, 10'd0,   1'b0, 1'b0};
        tbl[1]  = '{1'b1, 10'd17,  3'd2, 1'b0, 2'd0, 10'd400, 10'd9,  1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0};
        tbl[2]  = '{1'b0, 10'd300, 3'd1, 1'b0, 2'd1, 10'd5,   10'd6,  1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0};
        tbl[3]  = '{1'b0, 10'd0,   3'd0, 1'b0, 2'd1, 10'd5,   10'd10, 1'b0, 1'b0, 1'b0, 10'd10,  1'b0, 1'b0};
        tbl[4]  = '{1'b0, 10'd1023,3'd4, 1'b0, 2'd1, 10'd5,   10'd10, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0};
        tbl[5]  = '{1'b0, 10'd13,  3'd3, 1'b0, 2'd1, 10'd20,  10'd0,  1'b0, 1'b1, 1'b0, 10'd20,  1'b0, 1'b0};
        tbl[6]  = '{1'b0, 10'd13,  3'd3, 1'b1, 2'd1, 10'd20,  10'd0,  1'b0, 1'b1, 1'b0, 10'd14,  1'b0, 1'b0};
        tbl[7]  = '{1'b0, 10'd8,   3'd2, 1'b0, 2'd1, 10'd300, 10'd0,  1'b0, 1'b0, 1'b0, 10'd300, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 10'd500, 3'd7, 1'b0, 2'd1, 10'd300, 10'd0,  1'b0, 1'b0, 1'b0, 10'd500, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 10'd5,   3'd3, 1'b0, 2'd2, 10'd77,  10'd0,  1'b0, 1'b0, 1'b1, 10'd77,  1'b0, 1'b0};
        tbl[10] = '{1'b0, 10'd5,   3'd3, 1'b1, 2'd3, 10'd77,  10'd0,  1'b0, 1'b0, 1'b0, 10'd6,   1'b0, 1'b0};
        tbl[11] = '{1'b0, 10'd8,   3'd3, 1'b0, 2'd0, 10'd200, 10'd0,  1'b1, 1'b0, 1'b0, 10'd200, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Memory wait: 5 cycles looping, then moc arrives and it advances.
        for (int i = 0; i < 5; i++) begin
            apply(wait65(1'b0, 10'd65, 1'b0), $sformatf("wait_short%0d", i));
        end
        apply(wait65(1'b1, 10'd66, 1'b0), "wait_done");

        // Stuck wait: 15 loops, the 16th forces the fault state.
        for (int i = 0; i < 15; i++) begin
            apply(wait65(1'b0, 10'd65, 1'b0), $sformatf("wait_long%0d", i));
        end
        apply(wait65(1'b0, 10'd127, 1'b1), "wait_expire");

        // mem_timeout is sticky through normal operation, cleared by reset.
        v = op(3'd4, 10'd127, 10'd0, 10'd128);
        v.e_to = 1'b1;
        apply(v, "timeout_sticky");
        v = op(3'd4, 10'd127, 10'd0, 10'd0);
        v.rst = 1'b1;
        apply(v, "timeout_reset");

`ifdef MICRO_CALL_EN
        apply(op(3'd5, 10'd40, 10'd100, 10'd100), "call");
        apply(op(3'd6, 10'd100, 10'd0, 10'd41), "ret");

        // Four calls fill the stack; the fifth jumps but flags overflow.
        for (int i = 0; i < 4; i++) begin
            apply(op(3'd5, 10'(200 + i), 10'(300 + i), 10'(300 + i)),
                  $sformatf("nest_call%0d", i));
        end
        v = op(3'd5, 10'd204, 10'd304, 10'd304);
        v.e_se = 1'b1;
        apply(v, "nest_call_overflow");
        for (int i = 3; i >= 0; i--) begin
            v = op(3'd6, 10'd500, 10'd0, 10'(201 + i));
            v.e_se = 1'b1;
            apply(v, $sformatf("nest_ret%0d", i));
        end

        // Fresh underflow after reset.
        v = op(3'd6, 10'd50, 10'd0, 10'd0);
        v.rst = 1'b1;
        apply(v, "stack_reset");
        v = op(3'd6, 10'd50, 10'd0, 10'd0);
        v.e_se = 1'b1;
        apply(v, "ret_empty");
`else
        apply(op(3'd5, 10'd40, 10'd100, 10'd41), "call_as_inc");
        apply(op(3'd6, 10'd40, 10'd100, 10'd41), "ret_as_inc");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
